mem_bank_arbiter: RTL and testbench
===================================

Name: mem_bank_arbiter

Overview:
Two-requester round-robin arbiter and burst sequencer for one 256x8 data memory bank (synchronous write, combinational read). Each requester posts a burst command (base address, length, read/write). The arbiter grants the bank, drives one memory access per cycle with an incrementing address, streams write data in and read data out, and signals completion. One instance sits in front of each data memory bank.

Parameters:
BURST_W, 4, width of Len inputs; burst length = Len+1 beats (1..2^BURST_W)

Ports:
Clk  in  1  clock, all state updates on posedge
Rst  in  1  synchronous active-high reset
Req0/Req1  in  1  burst request; sampled only in IDLE
Wr0/Wr1  in  1  1=write burst, 0=read burst; sampled with Req
Addr0/Addr1  in  8  burst base address; sampled with Req
Len0/Len1  in  BURST_W  beats-1; sampled with Req
WData0/WData1  in  8  write beat data; consumed each ACCESS cycle while own Gnt=1
Gnt0/Gnt1  out  1  high during every ACCESS cycle of that requester's burst
RData0/RData1  out  8  registered read beat data
RValid0/RValid1  out  1  RData valid, one cycle after each read beat
Done0/Done1  out  1  one-cycle pulse, cycle after last beat
Busy  out  1  high while state=ACCESS
MemAddress  out  8  bank address
MemWriteData  out  8  bank write data
MemWrite  out  1  bank write enable
MemRead  out  1  bank read enable
MemReadData  in  8  bank read data (combinational from MemAddress)

Behaviour:
- Reset: state=IDLE, priority pointer=0, beat counter=0; Gnt*, RValid*, Done*, Busy, MemWrite, MemRead=0; RData*, MemAddress, MemWriteData=0.
- FSM: IDLE, ACCESS.
- IDLE: if any Req, pick winner (both high -> requester named by pointer; else the one requesting), latch Addr/Len/Wr, go ACCESS next cycle. No Req -> stay IDLE.
- ACCESS: one beat per cycle; Gnt(winner)=1, Busy=1; MemAddress = base + beat index, modulo 256 (255 wraps to 0). Write: MemWrite=1, MemWriteData=WData(winner) combinationally. Read: MemRead=1, RData(winner)<=MemReadData and RValid(winner)=1 next cycle.
- After beat Len (Len+1 beats total): go IDLE; Done(winner) pulses the following cycle, same cycle as last RValid for reads. Pointer <= other requester.
- Mandatory IDLE turnaround: each burst occupies Len+2 cycles from Req sample to next possible grant. Grant latency: first beat one cycle after Req is sampled in IDLE.
- Req in ACCESS is ignored. A requester must hold Req until it sees Gnt to be served. The loser keeps Req high and wins the next IDLE.
- Non-granted requester: Gnt=0, RValid=0, its RData holds its last value.
- MemWrite and MemRead are never both high. Both are 0 in IDLE.
- Rst mid-burst: at that edge all outputs return to reset values, remaining beats are dropped, no Done.

Optional Feature:
MEM_ARB_WRAP_CHECK_EN
- Defined: adds outputs Err0/Err1 (1 bit each). In IDLE, a winning request with Addr+Len > 255 is rejected: no ACCESS, no memory access. Err(winner) pulses one cycle later. Pointer still advances. Err*=0 on reset.
- Undefined: no Err ports; bursts wrap 255->0 as described.

Test Plan:
- Single write then read: Req0, Wr0=1, Addr0=0x10, Len0=3, WData0=0xA0..0xA3 -> Gnt0 for 4 cycles, mem[0x10..0x13]=A0..A3, Done0 pulse. Then read burst Len0=3 -> RValid0 4 cycles with RData0=A0,A1,A2,A3 and Done0 on the last RValid.
- Contention: Req0 and Req1 high in the same cycle after reset -> requester 0 served first, Req1 served after one IDLE cycle. Repeat -> requester 1 served first.
- Wrap: Addr1=0xFE, Len1=3, write 0x11..0x14 -> mem[FE]=11, mem[FF]=12, mem[00]=13, mem[01]=14. With MEM_ARB_WRAP_CHECK_EN: Err1 pulse, no MemWrite, memory unchanged.
- Reset mid-burst: Len0=15 write, Rst asserted on beat 5 -> MemWrite=0 from the next cycle, only 5 locations written, no Done0, state IDLE.
- Max/min length: Len=0 -> one beat, Done next cycle. Len=15 -> 16 beats, Busy high 16 cycles.
- Request during ACCESS: Req1 pulsed for one cycle only, in the middle of requester 0's burst -> never granted; memory bus shows only requester 0's beats.

Source files
------------

// File: rtl/mem_bank_arbiter_if.sv
// Requester and memory-bank bus for mem_bank_arbiter.
// Err0/Err1 exist only when MEM_ARB_WRAP_CHECK_EN is defined.
interface mem_bank_arbiter_if #(
    parameter int unsigned BURST_W = 4
);
    logic               req0;
    logic               req1;
    logic               wr0;
    logic               wr1;
    logic [7:0]         addr0;
    logic [7:0]         addr1;
    logic [BURST_W-1:0] len0;
    logic [BURST_W-1:0] len1;
    logic [7:0]         wdata0;
    logic [7:0]         wdata1;
    logic               gnt0;
    logic               gnt1;
    logic [7:0]         rdata0;
    logic [7:0]         rdata1;
    logic               rvalid0;
    logic               rvalid1;
    logic               done0;
    logic               done1;
    logic               busy;
    logic [7:0]         mem_address;
    logic [7:0]         mem_write_data;
    logic               mem_write;
    logic               mem_read;
    logic [7:0]         mem_read_data;
`ifdef MEM_ARB_WRAP_CHECK_EN
    logic               err0;
    logic               err1;
`endif

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, len0, len1, wdata0, wdata1, mem_read_data,
        output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, done0, done1, busy,
               mem_address, mem_write_data, mem_write, mem_read
`ifdef MEM_ARB_WRAP_CHECK_EN
        , output err0, err1
`endif
    );

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, len0, len1, wdata0, wdata1, mem_read_data,
        input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, done0, done1, busy,
               mem_address, mem_write_data, mem_write, mem_read
`ifdef MEM_ARB_WRAP_CHECK_EN
        , input err0, err1
`endif
    );
endinterface

// File: rtl/mem_bank_arbiter.sv
// Two-requester round-robin arbiter and burst sequencer for one 256x8 memory bank.
// Optional MEM_ARB_WRAP_CHECK_EN rejects bursts that would wrap past address 255.
module mem_bank_arbiter #(
    parameter int unsigned BURST_W = 4
) (
    input logic                clk,
    input logic                rst,
    mem_bank_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e             state_q, state_d;
    logic               ptr_q;
    logic               owner_q;
    logic               wr_q;
    logic [7:0]         base_q;
    logic [BURST_W-1:0] len_q;
    logic [BURST_W-1:0] beat_q;
    logic [1:0]         rvalid_q;
    logic [1:0]         done_q;
    logic [7:0]         rdata0_q;
    logic [7:0]         rdata1_q;
`ifdef MEM_ARB_WRAP_CHECK_EN
    logic [1:0]         err_q;
`endif

    logic               any_req;
    logic               win;
    logic [7:0]         win_addr;
    logic [BURST_W-1:0] win_len;
    logic               win_wr;
    logic               reject;
    logic               last_beat;

    logic [1:0]         gnt_v;
    logic               busy;
    logic [7:0]         mem_address;
    logic [7:0]         mem_write_data;
    logic               mem_write;
    logic               mem_read;

    // Winner selection is only meaningful in StIdle.
    assign any_req   = bus.req0 | bus.req1;
    assign win       = (bus.req0 & bus.req1) ? ptr_q : bus.req1;
    assign win_addr  = win ? bus.addr1 : bus.addr0;
    assign win_len   = win ? bus.len1 : bus.len0;
    assign win_wr    = win ? bus.wr1 : bus.wr0;
    assign last_beat = (beat_q == len_q);

`ifdef MEM_ARB_WRAP_CHECK_EN
    assign reject = ({1'b0, win_addr} + 9'(win_len)) > 9'd255;
`else
    assign reject = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any_req && !reject) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (last_beat) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt_v          = 2'b00;
        busy           = 1'b0;
        mem_address    = 8'h00;
        mem_write_data = 8'h00;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StAccess: begin
                gnt_v[owner_q] = 1'b1;
                busy           = 1'b1;
                mem_address    = base_q + 8'(beat_q);
                mem_write      = wr_q;
                mem_read       = ~wr_q;
                if (wr_q) begin
                    mem_write_data = owner_q ? bus.wdata1 : bus.wdata0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            wr_q     <= 1'b0;
            base_q   <= 8'h00;
            len_q    <= '0;
            beat_q   <= '0;
            rvalid_q <= 2'b00;
            done_q   <= 2'b00;
            rdata0_q <= 8'h00;
            rdata1_q <= 8'h00;
`ifdef MEM_ARB_WRAP_CHECK_EN
            err_q    <= 2'b00;
`endif
        end else begin
            rvalid_q <= 2'b00;
            done_q   <= 2'b00;
`ifdef MEM_ARB_WRAP_CHECK_EN
            err_q    <= 2'b00;
`endif
            unique case (state_q)
                StIdle: begin
                    beat_q <= '0;
                    if (any_req) begin
                        owner_q <= win;
                        base_q  <= win_addr;
                        len_q   <= win_len;
                        wr_q    <= win_wr;
                        if (reject) begin
                            ptr_q <= ~win;
`ifdef MEM_ARB_WRAP_CHECK_EN
                            err_q[win] <= 1'b1;
`endif
                        end
                    end
                end
                StAccess: begin
                    if (!wr_q) begin
                        rvalid_q[owner_q] <= 1'b1;
                        if (owner_q) begin
                            rdata1_q <= bus.mem_read_data;
                        end else begin
                            rdata0_q <= bus.mem_read_data;
                        end
                    end
                    if (last_beat) begin
                        beat_q          <= '0;
                        done_q[owner_q] <= 1'b1;
                        ptr_q           <= ~owner_q;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.gnt0           = gnt_v[0];
    assign bus.gnt1           = gnt_v[1];
    assign bus.busy           = busy;
    assign bus.mem_address    = mem_address;
    assign bus.mem_write_data = mem_write_data;
    assign bus.mem_write      = mem_write;
    assign bus.mem_read       = mem_read;
    assign bus.rvalid0        = rvalid_q[0];
    assign bus.rvalid1        = rvalid_q[1];
    assign bus.done0          = done_q[0];
    assign bus.done1          = done_q[1];
    assign bus.rdata0         = rdata0_q;
    assign bus.rdata1         = rdata1_q;
`ifdef MEM_ARB_WRAP_CHECK_EN
    assign bus.err0           = err_q[0];
    assign bus.err1           = err_q[1];
`endif

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Directed and randomized bench for mem_bank_arbiter with a burst-level reference model.
// Honours MEM_ARB_WRAP_CHECK_EN when the design is built with it.
module tb_mem_bank_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] wr = 2'b00;
    logic [7:0] addr [2];
    logic [3:0] len [2];
    logic [7:0] wdata [2];
    logic [7:0] cmd_data [2][16];

    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    logic       exp_ptr = 1'b0;

    int n_tot = 0;
    int n_pass = 0;
    int n_fail = 0;

    mem_bank_arbiter_if #(.BURST_W(4)) bus ();

    mem_bank_arbiter #(.BURST_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.req0   = req[0];
    assign bus.req1   = req[1];
    assign bus.wr0    = wr[0];
    assign bus.wr1    = wr[1];
    assign bus.addr0  = addr[0];
    assign bus.addr1  = addr[1];
    assign bus.len0   = len[0];
    assign bus.len1   = len[1];
    assign bus.wdata0 = wdata[0];
    assign bus.wdata1 = wdata[1];
    assign bus.mem_read_data = mem[bus.mem_address];

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_address] <= bus.mem_write_data;
    end

    logic [1:0] gnt_v, rvalid_v, done_v;
    logic [7:0] rdata_v [2];
    assign gnt_v      = {bus.gnt1, bus.gnt0};
    assign rvalid_v   = {bus.rvalid1, bus.rvalid0};
    assign done_v     = {bus.done1, bus.done0};
    assign rdata_v[0] = bus.rdata0;
    assign rdata_v[1] = bus.rdata1;
`ifdef MEM_ARB_WRAP_CHECK_EN
    logic [1:0] err_v;
    assign err_v = {bus.err1, bus.err0};
`endif

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        exp_ptr = 1'b0;
    endtask

    task automatic set_cmd(input int w, input logic wr_i, input logic [7:0] a, input logic [3:0] l,
                           input logic [7:0] d0, input bit rnd);
        wr[w]   = wr_i;
        addr[w] = a;
        len[w]  = l;
        for (int i = 0; i < 16; i++) cmd_data[w][i] = rnd ? 8'($urandom) : 8'(d0 + i);
    endtask

    function automatic logic [15:0] onehot(input int w);
        return (w != 0) ? 16'h2 : 16'h1;
    endfunction

    // Serves every requester in 'want' in model order; DUT must be idle on entry.
    task automatic serve(input logic [1:0] want, input int pulse_at);
        logic [1:0] pending;
        int         w, o;
        logic [7:0] a;
        pending = want;
        req     = want;
        while (pending != 2'b00) begin
            w = (pending == 2'b11) ? int'(exp_ptr) : (pending[1] ? 1 : 0);
            o = 1 - w;
            tick();
            req[w]     = 1'b0;
            pending[w] = 1'b0;
`ifdef MEM_ARB_WRAP_CHECK_EN
            if (int'(addr[w]) + int'(len[w]) > 255) begin
                #1;
                check("err_pulse", 16'(err_v), onehot(w));
                check("reject_gnt", 16'(gnt_v), 16'h0);
                check("reject_busy", 16'(bus.busy), 16'h0);
                check("reject_memwr", 16'(bus.mem_write), 16'h0);
                exp_ptr = o[0];
                continue;
            end
`endif
            for (int i = 0; i <= int'(len[w]); i++) begin
                wdata[w] = cmd_data[w][i];
                wdata[o] = 8'($urandom);
                if (pulse_at >= 0) req[o] = (i == pulse_at);
                #1;
                a = 8'(int'(addr[w]) + i);
                check("gnt", 16'(gnt_v), onehot(w));
                check("busy", 16'(bus.busy), 16'h1);
                check("mem_addr", 16'(bus.mem_address), 16'(a));
                check("mem_write", 16'(bus.mem_write), 16'(wr[w]));
                check("mem_read", 16'(bus.mem_read), 16'(!wr[w]));
                check("done_mid", 16'(done_v), 16'h0);
                if (wr[w]) begin
                    check("mem_wdata", 16'(bus.mem_write_data), 16'(cmd_data[w][i]));
                    ref_mem[a] = cmd_data[w][i];
                end
                if (!wr[w] && i > 0) begin
                    check("rvalid", 16'(rvalid_v), onehot(w));
                    check("rdata", 16'(rdata_v[w]), 16'(ref_mem[8'(a - 8'd1)]));
                end else begin
                    check("rvalid_off", 16'(rvalid_v), 16'h0);
                end
                tick();
            end
            if (pulse_at >= 0) req[o] = 1'b0;
            #1;
            a = 8'(int'(addr[w]) + int'(len[w]));
            check("done", 16'(done_v), onehot(w));
            check("idle_gnt", 16'(gnt_v), 16'h0);
            check("idle_busy", 16'(bus.busy), 16'h0);
            check("idle_mem", 16'({bus.mem_write, bus.mem_read}), 16'h0);
            if (wr[w]) begin
                check("last_rvalid_off", 16'(rvalid_v), 16'h0);
            end else begin
                check("last_rvalid", 16'(rvalid_v), onehot(w));
                check("last_rdata", 16'(rdata_v[w]), 16'(ref_mem[a]));
            end
            exp_ptr = o[0];
        end
    endtask

    initial begin
        logic [7:0] saved [4];
        for (int i = 0; i < 2; i++) begin
            addr[i] = 8'h00; len[i] = 4'h0; wdata[i] = 8'h00;
        end

        // Reset state
        do_reset();
        #1;
        check("rst_gnt", 16'(gnt_v), 16'h0);
        check("rst_busy", 16'(bus.busy), 16'h0);
        check("rst_mem", 16'({bus.mem_write, bus.mem_read}), 16'h0);
        check("rst_addr", 16'(bus.mem_address), 16'h0);
        check("rst_wdata", 16'(bus.mem_write_data), 16'h0);
        check("rst_rvalid", 16'(rvalid_v), 16'h0);
        check("rst_done", 16'(done_v), 16'h0);
        check("rst_rdata", {rdata_v[1], rdata_v[0]}, 16'h0);

        // Single write then read
        set_cmd(0, 1'b1, 8'h10, 4'd3, 8'hA0, 1'b0);
        serve(2'b01, -1);
        for (int i = 0; i < 4; i++) check("wr_mem", 16'(mem[8'h10 + i]), 16'(8'hA0 + i));
        set_cmd(0, 1'b0, 8'h10, 4'd3, 8'h00, 1'b0);
        serve(2'b01, -1);

        // Contention after reset: 0 first, then 1 after one idle cycle
        do_reset();
        set_cmd(0, 1'b1, 8'h20, 4'd1, 8'h30, 1'b0);
        set_cmd(1, 1'b1, 8'h28, 4'd1, 8'h40, 1'b0);
        serve(2'b11, -1);
        set_cmd(0, 1'b1, 8'h24, 4'd0, 8'h55, 1'b0);
        serve(2'b01, -1);
        set_cmd(0, 1'b0, 8'h20, 4'd1, 8'h00, 1'b0);
        set_cmd(1, 1'b0, 8'h28, 4'd1, 8'h00, 1'b0);
        serve(2'b11, -1);

        // Wrap past 255
        for (int i = 0; i < 4; i++) saved[i] = mem[8'(8'hFE + i)];
        set_cmd(1, 1'b1, 8'hFE, 4'd3, 8'h11, 1'b0);
        serve(2'b10, -1);
        tick();
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_WRAP_CHECK_EN
            check("wrap_mem_kept", 16'(mem[8'(8'hFE + i)]), 16'(saved[i]));
`else
            check("wrap_mem", 16'(mem[8'(8'hFE + i)]), 16'(8'h11 + i));
`endif
        end

        // Reset on the fifth beat of a 16-beat write
        set_cmd(0, 1'b1, 8'h40, 4'd15, 8'hB0, 1'b0);
        req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wdata[0] = cmd_data[0][i];
            if (i == 4) rst = 1'b1;
            #1;
            check("rstmid_memwr", 16'(bus.mem_write), 16'h1);
            ref_mem[8'(8'h40 + i)] = cmd_data[0][i];
            tick();
        end
        rst = 1'b0;
        exp_ptr = 1'b0;
        #1;
        check("rstmid_after_wr", 16'(bus.mem_write), 16'h0);
        check("rstmid_busy", 16'(bus.busy), 16'h0);
        check("rstmid_gnt", 16'(gnt_v), 16'h0);
        check("rstmid_done", 16'(done_v), 16'h0);
        tick();
        check("rstmid_done2", 16'(done_v), 16'h0);
        check("rstmid_idle", 16'(bus.busy), 16'h0);
        check("rstmid_last", 16'(mem[8'h44]), 16'hB4);
        check("rstmid_notwr", 16'(mem[8'h45]), 16'(ref_mem[8'h45]));

        // Min and max burst length
        set_cmd(1, 1'b1, 8'h70, 4'd0, 8'h7E, 1'b0);
        serve(2'b10, -1);
        set_cmd(0, 1'b1, 8'h80, 4'd15, 8'h60, 1'b0);
        serve(2'b01, -1);
        set_cmd(1, 1'b0, 8'h80, 4'd15, 8'h00, 1'b0);
        serve(2'b10, -1);

        // One-cycle Req1 pulse inside requester 0's burst is ignored
        set_cmd(0, 1'b1, 8'h90, 4'd7, 8'hC0, 1'b0);
        set_cmd(1, 1'b1, 8'hD0, 4'd2, 8'hE0, 1'b0);
        serve(2'b01, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pulse_no_gnt", 16'(gnt_v), 16'h0);
            check("pulse_no_busy", 16'(bus.busy), 16'h0);
        end
        check("pulse_mem_untouched", 16'(mem[8'hD0]), 16'(ref_mem[8'hD0]));

        // Randomized bursts against the model
        for (int n = 0; n < 60; n++) begin
            for (int w = 0; w < 2; w++) begin
                set_cmd(w, 1'($urandom), 8'($urandom), 4'($urandom), 8'h00, 1'b1);
            end
            serve(2'($urandom_range(1, 3)), -1);
        end
        tick();
        for (int i = 0; i < 256; i++) check("final_mem", 16'(mem[i]), 16'(ref_mem[i]));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
